// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg
//   Shared types and default widths for the L1 memory arbiter.
//   arb_state_t  : arbiter FSM state
//   arb_master_t : identifies the I-cache or D-cache master
package l1_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_I = 1'b0,
    M_D = 1'b1
  } arb_master_t;

endpackage

// File: rtl/l1_arb_rr_pick.sv
// l1_arb_rr_pick
//   Combinational two-way round-robin picker.
//   req_i, req_d : request from I-cache / D-cache
//   last_grant   : master that completed the previous transaction
//   grant        : master to serve next (meaningful only when a request is present)
module l1_arb_rr_pick
  import l1_arb_pkg::*;
(
  input  logic        req_i,
  input  logic        req_d,
  input  arb_master_t last_grant,
  output arb_master_t grant
);

  always_comb begin
    // Tie (or no request): favour the master that did not go last.
    grant = (last_grant == M_I) ? M_D : M_I;
    if (req_i && !req_d) begin
      grant = M_I;
    end else if (req_d && !req_i) begin
      grant = M_D;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Merges I-cache and D-cache line-fill / write-back requests onto one
//   memory port. Round-robin, grant held for a whole memory transaction,
//   one cycle of grant latency, no data latency.
//
//   clk, rst_n                 clock, async active-low reset
//   i_* / d_*                  cache-side stb/cyc/write/addr/wdata in,
//                              rdata/resp/retry out
//   mem_*                      memory-side stb/cyc/write/addr/wdata out,
//                              rdata/resp/retry in
//   perf_i_grants, perf_d_grants, perf_conflicts
//                              saturating counters, present only when
//                              ARB_PERF_EN is defined
//
//   state | meaning
//   IDLE  | no owner; requesters see retry
//   GNT_I | I-cache owns the memory port
//   GNT_D | D-cache owns the memory port
module l1_mem_arbiter
  import l1_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
`ifdef ARB_PERF_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_stb,
  input  logic              i_cyc,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  output logic              i_retry,

  input  logic              d_stb,
  input  logic              d_cyc,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              d_retry,

  output logic              mem_stb,
  output logic              mem_cyc,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  input  logic              mem_retry
`ifdef ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_i_grants,
  output logic [CNT_W-1:0]  perf_d_grants,
  output logic [CNT_W-1:0]  perf_conflicts
`endif
);

  arb_state_t  state;
  arb_master_t last_grant;
  arb_master_t pick;
  logic        i_req;
  logic        d_req;

  assign i_req = i_stb & i_cyc;
  assign d_req = d_stb & d_cyc;

  l1_arb_rr_pick u_pick (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // A completed transaction (mem_resp, even with cyc dropping the same
  // cycle) moves last_grant; an abort (cyc dropped, no resp) does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= M_I;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state <= (pick == M_I) ? GNT_I : GNT_D;
          end
        end
        GNT_I: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= M_I;
          end else if (!i_cyc) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= M_D;
          end else if (!d_cyc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The memory side is a straight combinational copy of the owner so no
  // data latency is added; stb is qualified by cyc so an abort drops both
  // in the same cycle.
  always_comb begin
    mem_stb   = 1'b0;
    mem_cyc   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_retry   = 1'b0;
    d_retry   = 1'b0;
    case (state)
      IDLE: begin
        i_retry = i_req;
        d_retry = d_req;
      end
      GNT_I: begin
        mem_stb   = i_stb & i_cyc;
        mem_cyc   = i_cyc;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_resp    = mem_resp;
        i_retry   = mem_retry;
        d_retry   = d_req;
      end
      GNT_D: begin
        mem_stb   = d_stb & d_cyc;
        mem_cyc   = d_cyc;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
        d_retry   = mem_retry;
        i_retry   = i_req;
      end
      default: begin
        i_retry = 1'b0;
        d_retry = 1'b0;
      end
    endcase
    // Outputs read as zero for as long as reset is held.
    if (!rst_n) begin
      i_retry = 1'b0;
      d_retry = 1'b0;
    end
  end

  // Read data is broadcast; each master qualifies it with its own resp.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

`ifdef ARB_PERF_EN
  logic inc_i;
  logic inc_d;
  logic conflict;

  assign inc_i    = (state == IDLE) && (i_req || d_req) && (pick == M_I);
  assign inc_d    = (state == IDLE) && (i_req || d_req) && (pick == M_D);
  assign conflict = ((state == IDLE)  && i_req && d_req) ||
                    ((state == GNT_I) && d_req) ||
                    ((state == GNT_D) && i_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (inc_i && (perf_i_grants != '1)) begin
        perf_i_grants <= perf_i_grants + CNT_W'(1);
      end
      if (inc_d && (perf_d_grants != '1)) begin
        perf_d_grants <= perf_d_grants + CNT_W'(1);
      end
      if (conflict && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Sits directly downstream of the two L1 cache controllers (instruction and data) and upstream of physical memory.
- Merges their stb/cyc/write/resp/retry line-fill and write-back requests onto the single memory port.
- Round-robin arbitration; a grant is held for one whole memory transaction.
- Adds one cycle of grant latency and no data latency.

Parameters:
- ADDR_W, 32, byte address width on every port.
- LINE_W, 256, cache-line data width on every port.
- CNT_W, 32, width of the performance counters (only used when ARB_PERF_EN is defined).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_stb, i_cyc, i_write  in  1  I-cache strobe, cycle, write request
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  LINE_W  I-cache write data
- i_rdata  out  LINE_W  read data to I-cache
- i_resp, i_retry  out  1  I-cache response, retry
- d_stb, d_cyc, d_write  in  1  D-cache strobe, cycle, write request
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write data
- d_rdata  out  LINE_W  read data to D-cache
- d_resp, d_retry  out  1  D-cache response, retry
- mem_stb, mem_cyc, mem_write  out  1  memory request
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data
- mem_resp, mem_retry  in  1  memory response, retry

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, last_grant=I, so D wins the first tie.
- Reset output values: all outputs 0, except i_rdata/d_rdata, which follow mem_rdata.
- A master "requests" when stb&cyc is high.
- States:
  - IDLE: no memory signals driven.
  - GNT_I: I-cache owns the memory port.
  - GNT_D: D-cache owns the memory port.
- IDLE transitions:
  - Only I requests -> GNT_I.
  - Only D requests -> GNT_D.
  - Both request -> grant the master that is not last_grant.
  - Neither requests -> stay in IDLE.
  - Grant takes effect the cycle after the request is first seen.
- While in GNT_x:
  - mem_stb/cyc/write/addr/wdata are combinational copies of master x's signals.
  - x_resp = mem_resp.
  - x_retry = mem_retry.
  - The other master sees y_resp=0 and y_retry = y_stb&y_cyc.
- In IDLE: every requesting master sees retry=1, resp=0.
- i_rdata and d_rdata are both driven with mem_rdata. Data is qualified only by the master's own resp.
- Leaving a grant:
  - mem_resp high in GNT_x -> next state IDLE, last_grant<=x.
  - No back-to-back grant without passing through IDLE, so a one-cycle bubble occurs between transactions.
- Abort: if master x drops cyc while in GNT_x without mem_resp, then mem_stb/cyc drop the same cycle, the next state is IDLE, no resp is given, and last_grant is unchanged.
- Simultaneous mem_resp and drop of cyc: treated as a completed transaction (resp delivered, last_grant<=x).
- mem_retry: the grant is held. mem_retry is forwarded as x_retry and has no effect on state.
- Reset asserted mid-transaction: immediately forces IDLE and zero outputs. The transaction is lost and the master must re-request.
- No arithmetic except the optional counters. The counters saturate at all-ones.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined: adds outputs perf_i_grants, perf_d_grants and perf_conflicts, each CNT_W bits.
  - perf_i_grants / perf_d_grants increment on each IDLE->GNT_I / IDLE->GNT_D transition.
  - perf_conflicts increments every cycle in which a master sees retry=1 because the other master holds the grant, or because both requested in IDLE.
  - All three reset to 0 and saturate at all-ones.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical.

Decomposition:
- Package l1_arb_pkg:
  - enum arb_state_t {IDLE, GNT_I, GNT_D}.
  - enum arb_master_t {M_I, M_D}.
  - Default constants for ADDR_W and LINE_W.
- Sub-module l1_arb_rr_pick: combinational two-way round-robin picker with inputs req_i, req_d, last_grant and output grant.

Test Plan:
- Reset, then I read only: i_stb=i_cyc=1, i_write=0, i_addr=0x100. Expect mem_addr=0x100 one cycle later. On mem_resp with mem_rdata=0xA5.., expect i_resp=1 and i_rdata=0xA5.. the same cycle, then IDLE.
- Simultaneous I and D requests just after reset: D granted first, I sees i_retry=1. After D's mem_resp, bubble, then I granted, and last_grant alternates on the next tie.
- D write-back followed immediately by a D read: mem_write=1 for the write. Expect one IDLE bubble, then mem_write=0 with the new address.
- mem_retry=1 for 3 cycles during GNT_I: expect i_retry=1 for those 3 cycles, the grant held, and d_retry=1 if D is requesting.
- Abort and reset: I drops cyc in GNT_I, expect mem_cyc=0 the same cycle and no i_resp. Separately, assert rst_n=0 mid GNT_D, expect all memory outputs 0 asynchronously.
- With ARB_PERF_EN defined: run 4 contested transactions, expect perf_i_grants=2, perf_d_grants=2, and perf_conflicts equal to the counted retry cycles.
